// File: rtl/instr_buffer.sv
// Instruction buffer: 4-wide packet enqueue into a circular FIFO, 1-wide in-order issue to decode.
// Optional same-cycle empty-buffer bypass of slot 0 when IB_BYPASS_EN is defined.
module instr_buffer #(
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic [127:0] admin2ib_instr,
    input  logic [3:0]   admin2ib_instr_valid,
    input  logic [3:0]   admin2ib_predicttaken,
    input  logic [127:0] admin2ib_predicttarget,
    input  logic [63:0]  admin2ib_pc,
    output logic         ib2admin_ready,
    output logic         ib2dec_valid,
    output logic [31:0]  ib2dec_instr,
    output logic [63:0]  ib2dec_pc,
    output logic         ib2dec_predicttaken,
    output logic [31:0]  ib2dec_predicttarget,
    input  logic         dec2ib_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;

    // Handshake: a transfer happens in any cycle where valid and ready are both high
    // on the rising edge; valid never depends on ready, and flush cancels both sides.

    logic [31:0] mem_instr  [DEPTH];
    logic [63:0] mem_pc     [DEPTH];
    logic        mem_taken  [DEPTH];
    logic [31:0] mem_target [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t count;
    logic empty, enq, deq, byp, byp_take;
    logic [2:0] n_in, n_wr;

    logic [3:0]    wr_en;
    logic [1:0]    src       [4];
    logic [AW-1:0] wr_idx    [4];
    logic [31:0]   wr_instr  [4];
    logic [63:0]   wr_pc     [4];
    logic          wr_taken  [4];
    logic [31:0]   wr_target [4];

    always_comb begin
        count          = wr_ptr_q - rd_ptr_q;
        empty          = (wr_ptr_q == rd_ptr_q);
        ib2admin_ready = (count <= ptr_t'(DEPTH - 4));
        n_in = {2'b0, admin2ib_instr_valid[0]} + {2'b0, admin2ib_instr_valid[1]}
             + {2'b0, admin2ib_instr_valid[2]} + {2'b0, admin2ib_instr_valid[3]};
        enq  = ib2admin_ready & (|admin2ib_instr_valid) & ~flush;
`ifdef IB_BYPASS_EN
        byp  = empty & enq;
`else
        byp  = 1'b0;
`endif
        byp_take = byp & dec2ib_ready;
        deq      = ~empty & dec2ib_ready & ~flush;
        // A consumed bypass slot 0 is never written; the remaining slots shift down one entry.
        n_wr     = enq ? (n_in - {2'b0, byp_take}) : 3'd0;

        for (int k = 0; k < 4; k++) begin
            src[k]       = 2'(k) + {1'b0, byp_take};
            wr_en[k]     = (3'(k) < n_wr);
            wr_idx[k]    = AW'(wr_ptr_q + ptr_t'(k));
            wr_instr[k]  = admin2ib_instr[32*src[k] +: 32];
            wr_pc[k]     = admin2ib_pc + {60'b0, src[k], 2'b00};
            wr_taken[k]  = admin2ib_predicttaken[src[k]];
            wr_target[k] = admin2ib_predicttarget[32*src[k] +: 32];
        end

        wr_ptr_d = flush ? '0 : wr_ptr_q + ptr_t'(n_wr);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ptr_t'(deq);

        ib2dec_valid         = (~empty | byp) & ~flush;
        ib2dec_instr         = '0;
        ib2dec_pc            = '0;
        ib2dec_predicttaken  = 1'b0;
        ib2dec_predicttarget = '0;
        if (byp) begin
            ib2dec_instr         = admin2ib_instr[31:0];
            ib2dec_pc            = admin2ib_pc;
            ib2dec_predicttaken  = admin2ib_predicttaken[0];
            ib2dec_predicttarget = admin2ib_predicttarget[31:0];
        end else if (ib2dec_valid) begin
            ib2dec_instr         = mem_instr[rd_ptr_q[AW-1:0]];
            ib2dec_pc            = mem_pc[rd_ptr_q[AW-1:0]];
            ib2dec_predicttaken  = mem_taken[rd_ptr_q[AW-1:0]];
            ib2dec_predicttarget = mem_target[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is live.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem_instr[wr_idx[k]]  <= wr_instr[k];
                mem_pc[wr_idx[k]]     <= wr_pc[k];
                mem_taken[wr_idx[k]]  <= wr_taken[k];
                mem_target[wr_idx[k]] <= wr_target[k];
            end
        end
    end

    valid_mask_contiguous: assert property (@(posedge clock) disable iff (reset)
        admin2ib_instr_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: directed vector table for basic issue, plus queue-model sequences
// for full, wrap-around, flush, simultaneous enq/deq and asynchronous reset.
module tb_instr_buffer;
    localparam int DEPTH = 16;
`ifdef IB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clock, reset, flush;
    logic [127:0] admin2ib_instr;
    logic [3:0]   admin2ib_instr_valid;
    logic [3:0]   admin2ib_predicttaken;
    logic [127:0] admin2ib_predicttarget;
    logic [63:0]  admin2ib_pc;
    logic         ib2admin_ready, ib2dec_valid, ib2dec_predicttaken, dec2ib_ready;
    logic [31:0]  ib2dec_instr, ib2dec_predicttarget;
    logic [63:0]  ib2dec_pc;

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .admin2ib_instr(admin2ib_instr),
        .admin2ib_instr_valid(admin2ib_instr_valid),
        .admin2ib_predicttaken(admin2ib_predicttaken),
        .admin2ib_predicttarget(admin2ib_predicttarget),
        .admin2ib_pc(admin2ib_pc),
        .ib2admin_ready(ib2admin_ready),
        .ib2dec_valid(ib2dec_valid),
        .ib2dec_instr(ib2dec_instr),
        .ib2dec_pc(ib2dec_pc),
        .ib2dec_predicttaken(ib2dec_predicttaken),
        .ib2dec_predicttarget(ib2dec_predicttarget),
        .dec2ib_ready(dec2ib_ready)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    logic [128:0] exp_q[$];   // {instr, pc, taken, target}
    int pkt = 0;

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_instr(input int p);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = 32'hA000_0000 | (32'(p) << 8) | 32'(i);
        return r;
    endfunction

    task automatic idle();
        flush = 1'b0;
        admin2ib_instr_valid   = 4'b0;
        admin2ib_instr         = '0;
        admin2ib_predicttaken  = 4'b0;
        admin2ib_predicttarget = '0;
        admin2ib_pc            = '0;
        dec2ib_ready           = 1'b0;
    endtask

    // driver + scoreboard for one clock cycle
    task automatic cycle(input logic fl, input logic [3:0] v, input logic [63:0] pc,
                         input logic [3:0] tk, input logic [127:0] tg, input logic rdy);
        logic m_ready, m_valid, byp;
        logic [128:0] head, got;
        logic [127:0] ins;
        int n;
        ins = mk_instr(pkt);
        pkt++;
        flush = fl; admin2ib_instr_valid = v; admin2ib_instr = ins; admin2ib_pc = pc;
        admin2ib_predicttaken = tk; admin2ib_predicttarget = tg; dec2ib_ready = rdy;
        n = $countones(v);
        @(negedge clock);
        m_ready = (DEPTH - exp_q.size()) >= 4;
        byp     = BYP && !fl && exp_q.size() == 0 && m_ready && n > 0;
        m_valid = !fl && (exp_q.size() != 0 || byp);
        head    = byp ? {ins[31:0], pc, tk[0], tg[31:0]} : (exp_q.size() != 0 ? exp_q[0] : '0);
        if (!m_valid) head = '0;
        got = {ib2dec_instr, ib2dec_pc, ib2dec_predicttaken, ib2dec_predicttarget};
        chk("ib2admin_ready", 129'(ib2admin_ready), 129'(m_ready));
        chk("ib2dec_valid", 129'(ib2dec_valid), 129'(m_valid));
        chk("ib2dec_head", got, head);
        if (fl) exp_q.delete();
        else begin
            if (m_valid && rdy && !byp) void'(exp_q.pop_front());
            if (m_ready && n > 0)
                for (int i = (byp && rdy) ? 1 : 0; i < n; i++)
                    exp_q.push_back({ins[32*i +: 32], pc + 64'(4*i), tk[i], tg[32*i +: 32]});
        end
        @(posedge clock); #1;
        idle();
    endtask

    task automatic push(input logic [3:0] v, input logic [63:0] pc);
        cycle(1'b0, v, pc, 4'b0, '0, 1'b0);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 4'b0, '0, 4'b0, '0, 1'b1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [63:0] exp_pc;
        logic        exp_ready;
    } vec_t;
    vec_t tv[6];

    initial begin
        logic [127:0] abcd;
        int k;
        abcd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        idle();
        reset = 1'b1;
        @(negedge clock);
        chk("reset_valid", 129'(ib2dec_valid), 129'(0));
        chk("reset_ready", 129'(ib2admin_ready), 129'(1));
        chk("reset_head", {ib2dec_instr, ib2dec_pc, ib2dec_predicttaken, ib2dec_predicttarget}, '0);
        @(posedge clock); #1;
        reset = 1'b0;

        // basic issue order: A,B,C,D at consecutive pcs
        for (int r = 0; r < 6; r++) begin
            k = BYP ? r : r - 1;
            tv[r].v         = (r == 0) ? 4'b1111 : 4'b0000;
            tv[r].rdy       = 1'b1;
            tv[r].exp_valid = (k >= 0 && k < 4);
            tv[r].exp_instr = tv[r].exp_valid ? abcd[32*k +: 32] : 32'h0;
            tv[r].exp_pc    = tv[r].exp_valid ? 64'h1000 + 64'(4*k) : 64'h0;
            tv[r].exp_ready = 1'b1;
        end
        for (int r = 0; r < 6; r++) begin
            admin2ib_instr_valid = tv[r].v; admin2ib_instr = abcd; admin2ib_pc = 64'h1000;
            dec2ib_ready = tv[r].rdy;
            @(negedge clock);
            chk($sformatf("vec%0d_valid", r), 129'(ib2dec_valid), 129'(tv[r].exp_valid));
            chk($sformatf("vec%0d_instr", r), 129'(ib2dec_instr), 129'(tv[r].exp_instr));
            chk($sformatf("vec%0d_pc", r), 129'(ib2dec_pc), 129'(tv[r].exp_pc));
            chk($sformatf("vec%0d_ready", r), 129'(ib2admin_ready), 129'(tv[r].exp_ready));
            @(posedge clock); #1;
            idle();
        end

        // full: five packets offered, fifth refused, head intact, then drain
        apply_reset();
        for (int i = 0; i < 5; i++) push(4'b1111, 64'h4000 + 64'(16*i));
        chk("full_ready", 129'(ib2admin_ready), 129'(0));
        chk("full_head_instr", 129'(ib2dec_instr), 129'(mk_instr(pkt - 5) & 128'hFFFF_FFFF));
        chk("full_head_pc", 129'(ib2dec_pc), 129'(64'h4000));
        drain(17);

        // wrap: pointers at 14, packet straddles 15 -> 0
        apply_reset();
        for (int i = 0; i < 3; i++) push(4'b1111, 64'h100 + 64'(16*i));
        push(4'b0011, 64'h200);
        drain(14);
        cycle(1'b0, 4'b0111, 64'h3000, 4'b0100, {32'h0, 32'h2000, 32'h0, 32'h0}, 1'b0);
        drain(2);
        chk("wrap_third_taken", 129'(ib2dec_predicttaken), 129'(1));
        chk("wrap_third_target", 129'(ib2dec_predicttarget), 129'(32'h2000));
        chk("wrap_third_pc", 129'(ib2dec_pc), 129'(64'h3008));
        drain(2);

        // flush with enq and deq in the same cycle, 5 buffered
        apply_reset();
        push(4'b1111, 64'h500);
        push(4'b0001, 64'h600);
        cycle(1'b1, 4'b1111, 64'h700, 4'b0, '0, 1'b1);
        chk("flush_next_valid", 129'(ib2dec_valid), 129'(0));
        chk("flush_next_ready", 129'(ib2admin_ready), 129'(1));
        push(4'b0001, 64'h800);
        drain(2);

        // simultaneous enq of 2 and deq with 3 buffered
        apply_reset();
        push(4'b0111, 64'h900);
        cycle(1'b0, 4'b0011, 64'hA00, 4'b0, '0, 1'b1);
        drain(5);

        // asynchronous reset mid-stream with 9 buffered
        apply_reset();
        push(4'b1111, 64'hB00);
        push(4'b1111, 64'hB10);
        push(4'b0001, 64'hB20);
        chk("async_pre_valid", 129'(ib2dec_valid), 129'(1));
        #1 reset = 1'b1;
        #1;
        chk("async_valid", 129'(ib2dec_valid), 129'(0));
        chk("async_ready", 129'(ib2admin_ready), 129'(1));
        chk("async_instr", 129'(ib2dec_instr), 129'(0));
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        push(4'b0011, 64'hC00);
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Instruction buffer between the fetch-side admin stage and decode. Each cycle it accepts a packet of up to four aligned, branch-trimmed instructions with per-slot prediction info, and stores them in a circular FIFO. It issues them in program order, one per cycle, to decode through a valid/ready handshake. A flush from the backend or PC control discards all buffered contents.

## Interface
- `DEPTH`, 16: number of instruction entries; power of two, ≥ 8.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flush` input 1: redirect; clears the buffer.
- `admin2ib_instr` input 128: four 32-bit instructions; slot i is at [32i+31:32i].
- `admin2ib_instr_valid` input 4: per-slot valid, always contiguous from slot 0 (0000/0001/0011/0111/1111).
- `admin2ib_predicttaken` input 4: per-slot predicted taken.
- `admin2ib_predicttarget` input 128: per-slot 32-bit predicted target.
- `admin2ib_pc` input 64: PC of slot 0.
- `ib2admin_ready` output 1: buffer can accept a full 4-instruction packet.
- `ib2dec_valid` output 1: head entry presented.
- `ib2dec_instr` output 32: head instruction.
- `ib2dec_pc` output 64: head PC.
- `ib2dec_predicttaken` output 1: head predicted-taken.
- `ib2dec_predicttarget` output 32: head predicted target.
- `dec2ib_ready` input 1: decode accepts the head this cycle.

## Operation
- Storage: DEPTH entries, each holding {instr[31:0], pc[63:0], predicttaken, predicttarget[31:0]}.
- Pointers:
  - `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = wr_ptr − rd_ptr, computed modulo 2·DEPTH.
  - empty when the pointers are equal; full when the low bits are equal and the wrap bits differ.
- Enqueue:
  - Condition: enq = ib2admin_ready & |admin2ib_instr_valid & ~flush.
  - n = popcount(valid), 1..4.
  - Slot i (i < n) is written to entry (wr_ptr+i) mod DEPTH with pc = admin2ib_pc + 4·i, computed in 64-bit and wrapping.
  - wr_ptr advances by n.
- Ready: ib2admin_ready = (DEPTH − count) ≥ 4. It depends on registered state only, never on dequeue in the same cycle.
- Dequeue:
  - Condition: deq = ib2dec_valid & dec2ib_ready & ~flush.
  - rd_ptr advances by 1.
- Simultaneous enq and deq: both apply in the same cycle; count changes by n−1.
- Flush:
  - Highest priority. Next cycle wr_ptr = rd_ptr = 0.
  - The same-cycle enqueue and dequeue are dropped, and ib2dec_valid is forced to 0 in the flush cycle.
- Outputs: ib2dec_* are read combinationally from entry rd_ptr; ib2dec_valid = ~empty & ~flush.
- Illegal input: a non-contiguous valid mask is illegal. The simulation assertion fires; hardware behaviour is undefined.

## Timing
- Reset values (asynchronous):
  - pointers 0, ib2dec_valid 0, ib2admin_ready 1.
  - ib2dec_instr/pc/predicttaken/predicttarget are 0 (outputs gated by valid).
  - Storage contents are not reset.
- Latency without bypass: an instruction enqueued in cycle t is visible at ib2dec in t+1 at the earliest.
- Throughput: 4 in and 1 out per cycle. Ready deasserts once count > DEPTH−4 and reasserts the cycle after count drops to ≤ DEPTH−4.
- Wrap-around: a packet may straddle entry DEPTH−1→0; slot order is preserved.
- Reset asserted mid-operation empties the buffer immediately and asynchronously; no partial packet survives.

## Configuration
- `IB_BYPASS_EN` defined:
  - When the buffer is empty, enq is asserted and there is no flush, slot 0 of the incoming packet drives ib2dec_* in the same cycle with ib2dec_valid = 1.
  - If dec2ib_ready, slot 0 is consumed: only slots 1..n−1 are written and wr_ptr advances by n−1.
  - Otherwise all n slots are written normally.
- `IB_BYPASS_EN` undefined: no combinational path from admin2ib_* to ib2dec_*; latency is as stated in Timing.

## Test plan
- Reset, then push valid=1111, pc=0x1000, instrs A,B,C,D, with dec2ib_ready=1 → ib2dec issues A@0x1000, B@0x1004, C@0x1008, D@0x100C on consecutive cycles starting t+1 (t with `IB_BYPASS_EN`).
- Push 1111 every cycle with dec2ib_ready=0, DEPTH=16 → four packets accepted; ready=0 once count=16; no overwrite of the head.
- Pointer wrap: fill to 14, drain 14, push valid=0111 with predicttaken=0100 and target 0x2000 → entries straddle index 15→0; the third issued instruction shows predicttaken=1 and target 0x2000.
- Flush in the same cycle as enq and deq with 5 entries buffered → ib2dec_valid=0 that cycle, count=0 next cycle, the incoming packet is dropped, and ready=1.
- Simultaneous enq of 0011 and deq with count=3 → count=4 next cycle and order is preserved.
- Assert reset asynchronously mid-stream with count=9 → ib2dec_valid drops before the next clock edge and ready=1.
